// File: rtl/cbc_pkg.sv
// Shared types and constants for the AES CBC-decrypt block sequencer.
package cbc_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  // Any ksize with the top bit set selects AES-256.
  function automatic int unsigned max_round(input logic [1:0] ks);
    if (ks[1])            return NR_256;
    else if (ks == KS_192) return NR_192;
    else                   return NR_128;
  endfunction

endpackage

// File: rtl/cbc_dec_sched_if.sv
// Host/DMA side bundle: IV load, ciphertext in and plaintext out.
// Carries the ecb bit only when CBC_DEC_SCHED_ECB_EN is defined.
interface cbc_dec_sched_if;
  import cbc_pkg::*;

  logic             iv_load;
  logic [BLK_W-1:0] iv;
  logic [1:0]       ksize;
  logic             in_vld;
  logic             in_rdy;
  logic [BLK_W-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [BLK_W-1:0] out_data;
`ifdef CBC_DEC_SCHED_ECB_EN
  logic             ecb;

  modport master (output iv_load, iv, ksize, in_vld, in_data, out_rdy, ecb,
                  input  in_rdy, out_vld, out_data);
  modport slave  (input  iv_load, iv, ksize, in_vld, in_data, out_rdy, ecb,
                  output in_rdy, out_vld, out_data);
`else
  modport master (output iv_load, iv, ksize, in_vld, in_data, out_rdy,
                  input  in_rdy, out_vld, out_data);
  modport slave  (input  iv_load, iv, ksize, in_vld, in_data, out_rdy,
                  output in_rdy, out_vld, out_data);
`endif

endinterface

// File: rtl/cbc_chain_reg.sv
// IV / previous-ciphertext register; plain is the core result XORed with the chain value.
module cbc_chain_reg
  import cbc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BLK_W-1:0] load_val,
  input  logic             upd,
  input  logic [BLK_W-1:0] upd_val,
  input  logic [BLK_W-1:0] dec,
  output logic [BLK_W-1:0] plain
);

  logic [BLK_W-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst)       chain <= '0;
    else if (load) chain <= load_val;
    else if (upd)  chain <= upd_val;
  end

  assign plain = dec ^ chain;

endmodule

// File: rtl/cbc_dec_sched.sv
// AES CBC-decrypt block sequencer: feeds one ciphertext block at a time to the round
// controller and chains the result. CBC_DEC_SCHED_ECB_EN adds a per-block ECB bypass.
module cbc_dec_sched
  import cbc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  cbc_dec_sched_if.slave      host,
  output logic                core_en,
  output logic                core_go,
  output logic [1:0]          core_ksize,
  output logic [BLK_W-1:0]    core_din,
  input  logic                core_dout_vld,
  input  logic [BLK_W-1:0]    core_dout,
  output logic [CNT_W-1:0]    blk_cnt,
  output logic                busy,
  output logic                iv_err
);

  state_t           state, nxt;
  logic             in_rdy_c, out_vld_c;
  logic             accept, done_evt, iv_ok;
  logic             ecb_cur;
  logic [BLK_W-1:0] cur, plain, out_data_q;

  assign accept   = host.in_vld & in_rdy_c;
  assign done_evt = (state == RUN) & core_dout_vld;
  assign iv_ok    = (state == IDLE) & host.iv_load;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept)        nxt = RUN;
      RUN:     if (core_dout_vld) nxt = DONE;
      DONE:    if (host.out_rdy)  nxt = IDLE;
      default:                    nxt = IDLE;
    endcase
  end

  // go is low in IDLE and DONE, so the round counter sees a low cycle between blocks
  always_comb begin
    in_rdy_c  = 1'b0;
    core_go   = 1'b0;
    core_en   = 1'b0;
    out_vld_c = 1'b0;
    case (state)
      IDLE:    in_rdy_c  = ~host.iv_load;
      RUN:     begin core_go = 1'b1; core_en = 1'b1; end
      DONE:    out_vld_c = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state != IDLE);
  assign host.in_rdy   = in_rdy_c;
  assign host.out_vld  = out_vld_c;
  assign host.out_data = out_data_q;
  assign core_din      = cur;

`ifdef CBC_DEC_SCHED_ECB_EN
  logic ecb_q;
  always_ff @(posedge clk) begin
    if (rst)         ecb_q <= 1'b0;
    else if (accept) ecb_q <= host.ecb;
  end
  assign ecb_cur = ecb_q;
`else
  assign ecb_cur = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      out_data_q <= '0;
      blk_cnt    <= '0;
      core_ksize <= '0;
      iv_err     <= 1'b0;
    end else begin
      iv_err <= host.iv_load & (state != IDLE);
      if (iv_ok) begin
        core_ksize <= host.ksize;
        blk_cnt    <= '0;
      end
      if (accept) cur <= host.in_data;
      if (done_evt) begin
        out_data_q <= ecb_cur ? core_dout : plain;
        blk_cnt    <= blk_cnt + CNT_W'(1);
      end
    end
  end

  cbc_chain_reg u_chain (
    .clk      (clk),
    .rst      (rst),
    .load     (iv_ok),
    .load_val (host.iv),
    .upd      (done_evt & ~ecb_cur),
    .upd_val  (cur),
    .dec      (core_dout),
    .plain    (plain)
  );

endmodule

// File: tb/tb_cbc_dec_sched.sv
// Self-checking bench for cbc_dec_sched with a stub AES core and a CBC reference model.
module tb_cbc_dec_sched;
  import cbc_pkg::*;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbc_dec_sched_if host ();

  logic             core_en, core_go;
  logic [1:0]       core_ksize;
  logic [BLK_W-1:0] core_din;
  logic             core_dout_vld = 1'b0;
  logic [BLK_W-1:0] core_dout = '0;
  logic [CNT_W-1:0] blk_cnt;
  logic             busy, iv_err;

  cbc_dec_sched #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (host),
    .core_en       (core_en),
    .core_go       (core_go),
    .core_ksize    (core_ksize),
    .core_din      (core_din),
    .core_dout_vld (core_dout_vld),
    .core_dout     (core_dout),
    .blk_cnt       (blk_cnt),
    .busy          (busy),
    .iv_err        (iv_err)
  );

  int checks = 0;
  int failures = 0;

  // Stub core: pulses dout_vld after lat cycles of go high; go-low restarts it.
  int   lat = 4;
  int   stub_cnt = 0;
  int   go_violations = 0;
  logic prev_fin = 1'b0;

  function automatic logic [BLK_W-1:0] dec_fn(input logic [BLK_W-1:0] c);
    return {c[63:0], c[127:64]} ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
  endfunction

  function automatic logic [BLK_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (prev_fin && core_go) go_violations++;
    if (core_go) begin
      stub_cnt++;
      if (stub_cnt == lat) begin
        core_dout_vld = 1'b1;
        core_dout     = dec_fn(core_din);
      end else begin
        core_dout_vld = 1'b0;
      end
    end else begin
      stub_cnt      = 0;
      core_dout_vld = 1'b0;
    end
    prev_fin = core_dout_vld && core_go;
  end

  // Reference model: CBC chain value and blocks since IV.
  logic [BLK_W-1:0] m_chain;
  int               m_cnt;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input logic [BLK_W-1:0] v, input logic [1:0] ks);
    host.iv      = v;
    host.ksize   = ks;
    host.iv_load = 1'b1;
    cycle();
    host.iv_load = 1'b0;
    m_chain      = v;
    m_cnt        = 0;
  endtask

  task automatic send_block(input logic [BLK_W-1:0] c, input bit consume,
                            output logic [BLK_W-1:0] got, output logic [CNT_W-1:0] cnt,
                            output bit ok);
    logic acc;
    ok           = 1'b0;
    host.in_data = c;
    host.in_vld  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = host.in_rdy;
      cycle();
      if (acc) begin ok = 1'b1; break; end
    end
    host.in_vld = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (host.out_vld) begin ok = 1'b1; break; end
      end
    end
    got = host.out_data;
    cnt = blk_cnt;
    if (ok && consume) begin
      host.out_rdy = 1'b1;
      cycle();
      host.out_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    checks++;
    if ({host.in_rdy, busy, host.out_vld, core_go, core_en, iv_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100000",
               {host.in_rdy, busy, host.out_vld, core_go, core_en, iv_err});
    end
    checks++;
    if ({blk_cnt, core_ksize} !== '0) begin
      failures++;
      $display("FAIL reset_cnt_ks got=%0d/%0d exp=0/0", blk_cnt, core_ksize);
    end
    checks++;
    if (host.out_data !== '0 || core_din !== '0) begin
      failures++;
      $display("FAIL reset_data out=%h din=%h exp=0", host.out_data, core_din);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    logic [BLK_W-1:0] c, exp;
    int n;
    lat = 44;
    load_iv(128'h000102030405060708090A0B0C0D0E0F, 2'b00);
    c = rnd128();
    host.in_data = c;
    host.in_vld  = 1'b1;
    @(negedge clk);
    checks++;
    if (host.in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL single_in_rdy got=%b exp=1", host.in_rdy);
    end
    cycle();
    host.in_vld = 1'b0;
    checks++;
    if ({core_go, core_en, busy} !== 3'b111 || core_din !== c) begin
      failures++;
      $display("FAIL single_go go/en/busy=%b din=%h exp=111 %h", {core_go, core_en, busy}, core_din, c);
    end
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (host.out_vld) begin n = i; break; end
    end
    exp = dec_fn(c) ^ m_chain;
    checks++;
    if (n != lat + 1) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=%0d", n, lat + 1);
    end
    checks++;
    if (host.out_data !== exp || blk_cnt !== CNT_W'(1) || core_ksize !== 2'b00) begin
      failures++;
      $display("FAIL single_data got=%h cnt=%0d ks=%0d exp=%h cnt=1 ks=0",
               host.out_data, blk_cnt, core_ksize, exp);
    end
    host.out_rdy = 1'b1;
    cycle();
    host.out_rdy = 1'b0;
    m_chain = c;
    m_cnt   = 1;
  endtask

  task automatic test_back_to_back();
    logic [BLK_W-1:0] c, got, exp;
    logic [CNT_W-1:0] cnt;
    bit ok;
    load_iv(rnd128(), 2'b01);
    go_violations = 0;
    for (int b = 0; b < 3; b++) begin
      lat = $urandom_range(1, 8);
      c   = rnd128();
      send_block(c, 1'b1, got, cnt, ok);
      exp     = dec_fn(c) ^ m_chain;
      m_chain = c;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      checks++;
      if (!ok || got !== exp || cnt !== CNT_W'(m_cnt)) begin
        failures++;
        $display("FAIL b2b_blk%0d ok=%0d got=%h cnt=%0d exp=%h cnt=%0d", b, ok, got, cnt, exp, m_cnt);
      end
    end
    checks++;
    if (go_violations != 0 || core_ksize !== 2'b01) begin
      failures++;
      $display("FAIL b2b_go_gap violations=%0d ks=%0d exp=0 ks=1", go_violations, core_ksize);
    end
  endtask

  task automatic test_backpressure();
    logic [BLK_W-1:0] c, got, exp;
    logic [CNT_W-1:0] cnt;
    bit ok;
    int bad;
    lat = 3;
    c   = rnd128();
    send_block(c, 1'b0, got, cnt, ok);
    exp     = dec_fn(c) ^ m_chain;
    m_chain = c;
    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL bp_data ok=%0d got=%h exp=%h", ok, got, exp);
    end
    host.in_vld  = 1'b1;
    host.in_data = rnd128();
    bad = 0;
    repeat (10) begin
      cycle();
      @(negedge clk);
      if (host.out_vld !== 1'b1 || host.out_data !== exp || host.in_rdy !== 1'b0 || core_go !== 1'b0)
        bad++;
    end
    host.in_vld = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d exp=0", bad);
    end
    host.out_rdy = 1'b1;
    cycle();
    host.out_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || host.out_vld !== 1'b0) begin
      failures++;
      $display("FAIL bp_release busy=%b out_vld=%b exp=0 0", busy, host.out_vld);
    end
  endtask

  task automatic test_iv_load();
    logic [BLK_W-1:0] c, got, exp, niv;
    logic [CNT_W-1:0] cnt;
    bit ok;
    lat = 20;
    c = rnd128();
    host.in_data = c;
    host.in_vld  = 1'b1;
    cycle();
    host.in_vld = 1'b0;
    repeat (5) cycle();
    host.iv      = rnd128();
    host.ksize   = 2'b10;
    host.iv_load = 1'b1;
    cycle();
    host.iv_load = 1'b0;
    checks++;
    if (iv_err !== 1'b1) begin
      failures++;
      $display("FAIL iv_err_pulse got=%b exp=1", iv_err);
    end
    cycle();
    checks++;
    if (iv_err !== 1'b0) begin
      failures++;
      $display("FAIL iv_err_width got=%b exp=0", iv_err);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (host.out_vld) begin ok = 1'b1; break; end
    end
    exp     = dec_fn(c) ^ m_chain;
    m_chain = c;
    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
    checks++;
    if (!ok || host.out_data !== exp || core_ksize !== 2'b01) begin
      failures++;
      $display("FAIL iv_ignored ok=%0d got=%h ks=%0d exp=%h ks=1", ok, host.out_data, core_ksize, exp);
    end
    host.out_rdy = 1'b1;
    cycle();
    host.out_rdy = 1'b0;
    niv          = rnd128();
    host.iv      = niv;
    host.ksize   = 2'b10;
    host.iv_load = 1'b1;
    host.in_vld  = 1'b1;
    host.in_data = rnd128();
    @(negedge clk);
    checks++;
    if (host.in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL collide_in_rdy got=%b exp=0", host.in_rdy);
    end
    cycle();
    host.iv_load = 1'b0;
    host.in_vld  = 1'b0;
    m_chain = niv;
    m_cnt   = 0;
    checks++;
    if (busy !== 1'b0 || core_ksize !== 2'b10 || blk_cnt !== '0) begin
      failures++;
      $display("FAIL collide_load busy=%b ks=%0d cnt=%0d exp=0 2 0", busy, core_ksize, blk_cnt);
    end
    c = rnd128();
    lat = 5;
    send_block(c, 1'b1, got, cnt, ok);
    exp     = dec_fn(c) ^ m_chain;
    m_chain = c;
    m_cnt   = 1;
    checks++;
    if (!ok || got !== exp || cnt !== CNT_W'(1)) begin
      failures++;
      $display("FAIL collide_next ok=%0d got=%h cnt=%0d exp=%h cnt=1", ok, got, cnt, exp);
    end
  endtask

  task automatic test_rst_mid_run();
    int seen;
    lat = 30;
    host.in_data = rnd128();
    host.in_vld  = 1'b1;
    cycle();
    host.in_vld = 1'b0;
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({host.in_rdy, busy, host.out_vld, core_go, core_en, iv_err} !== 6'b100000 ||
        blk_cnt !== '0 || core_din !== '0 || core_ksize !== '0 || host.out_data !== '0) begin
      failures++;
      $display("FAIL rst_mid_run ctrl=%b cnt=%0d din=%h exp=100000 0 0",
               {host.in_rdy, busy, host.out_vld, core_go, core_en, iv_err}, blk_cnt, core_din);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (host.out_vld || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_abort active_cycles=%0d exp=0", seen);
    end
    m_chain = '0;
    m_cnt   = 0;
  endtask

  task automatic test_cnt_wrap();
    logic [BLK_W-1:0] c, got, exp;
    logic [CNT_W-1:0] cnt;
    bit ok;
    int exp_cnt [5] = '{1, 2, 3, 0, 1};
    load_iv(rnd128(), 2'b00);
    for (int b = 0; b < 5; b++) begin
      lat = $urandom_range(1, 6);
      c   = rnd128();
      send_block(c, 1'b1, got, cnt, ok);
      exp     = dec_fn(c) ^ m_chain;
      m_chain = c;
      checks++;
      if (!ok || got !== exp || cnt !== CNT_W'(exp_cnt[b])) begin
        failures++;
        $display("FAIL wrap_blk%0d ok=%0d got=%h cnt=%0d exp=%h cnt=%0d", b, ok, got, cnt, exp, exp_cnt[b]);
      end
    end
    m_cnt = 1;
  endtask

`ifdef CBC_DEC_SCHED_ECB_EN
  task automatic test_ecb();
    logic [BLK_W-1:0] c, got, exp;
    logic [CNT_W-1:0] cnt;
    bit ok;
    lat = 4;
    host.ecb = 1'b1;
    c = rnd128();
    send_block(c, 1'b1, got, cnt, ok);
    exp = dec_fn(c);
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL ecb_data ok=%0d got=%h exp=%h", ok, got, exp);
    end
    host.ecb = 1'b0;
    c = rnd128();
    send_block(c, 1'b1, got, cnt, ok);
    exp     = dec_fn(c) ^ m_chain;
    m_chain = c;
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL ecb_chain_kept ok=%0d got=%h exp=%h", ok, got, exp);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    host.iv_load = 1'b0;
    host.iv      = '0;
    host.ksize   = '0;
    host.in_vld  = 1'b0;
    host.in_data = '0;
    host.out_rdy = 1'b0;
`ifdef CBC_DEC_SCHED_ECB_EN
    host.ecb     = 1'b0;
`endif
    m_chain = '0;
    m_cnt   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_iv_load();
    test_rst_mid_run();
    test_cnt_wrap();
`ifdef CBC_DEC_SCHED_ECB_EN
    test_ecb();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
